// File: rtl/seq_det_pkg.sv
// Shared constants and the elaboration-time prefix-match function for the
// serial pattern detector.
//   SEQ_DET_MAX_LEN  : longest supported pattern
//   STATE_W          : width of the prefix-length state (0..SEQ_DET_MAX_LEN)
//   SEQ_DET_MOORE/MEALY : values for the MOORE parameter
package seq_det_pkg;

   localparam int unsigned SEQ_DET_MAX_LEN = 16;
   localparam int unsigned STATE_W         = 5;
   localparam int unsigned SEQ_DET_MOORE   = 1;
   localparam int unsigned SEQ_DET_MEALY   = 0;

   // Longest k <= len such that the first k pattern bits equal the last k bits
   // of (first s pattern bits followed by b). Pattern bit len-1 is received first.
   function automatic logic [STATE_W-1:0] prefix_match_len(
      input logic [SEQ_DET_MAX_LEN-1:0] pat,
      input int unsigned                len,
      input int unsigned                s,
      input logic                       b
   );
      logic [SEQ_DET_MAX_LEN:0] hist;
      int unsigned              best;
      logic                     ok;
      hist = '0;
      best = 0;
      // hist[i] is the i-th bit of the accepted history, oldest first
      for (int unsigned i = 0; i < SEQ_DET_MAX_LEN; i++) begin
         if (i < s) hist[5'(i)] = pat[4'(len - 1 - i)];
      end
      hist[5'(s)] = b;
      // Ascending search so the last hit is the longest match
      for (int unsigned k = 1; k <= SEQ_DET_MAX_LEN; k++) begin
         if (k <= len && k <= s + 1) begin
            ok = 1'b1;
            for (int unsigned j = 0; j < SEQ_DET_MAX_LEN; j++) begin
               if (j < k) begin
                  if (pat[4'(len - 1 - j)] != hist[5'(s + 1 - k + j)]) ok = 1'b0;
               end
            end
            if (ok) best = k;
         end
      end
      return STATE_W'(best);
   endfunction

endpackage

// File: rtl/seq_det_next_state.sv
// Combinational next-state lookup d(s,b) for the prefix-length detector.
// The full table is folded to constants at elaboration.
//   s_i   : current prefix length
//   b_i   : incoming serial bit
//   nxt_c : next prefix length (combinational)
module seq_det_next_state
   import seq_det_pkg::*;
#(
   parameter int unsigned PATTERN_LEN = 3,
   parameter logic [SEQ_DET_MAX_LEN-1:0] PATTERN = 16'b011,
   parameter int unsigned OVERLAP     = 1
) (
   input  logic [STATE_W-1:0] s_i,
   input  logic               b_i,
   output logic [STATE_W-1:0] nxt_c
);

   localparam int unsigned TBL_DEPTH = 2 ** (STATE_W + 1);

   logic [STATE_W-1:0] tbl [TBL_DEPTH];

   // Entry {s,b}; unreachable states fall back to the empty prefix
   for (genvar gs = 0; gs < 2 ** STATE_W; gs++) begin : g_s
      for (genvar gb = 0; gb < 2; gb++) begin : g_b
         if (gs <= PATTERN_LEN) begin : g_live
            // Without overlap a full match restarts from an empty history
            localparam int unsigned SRC =
               (OVERLAP == 0 && gs == PATTERN_LEN) ? 0 : gs;
            localparam logic [STATE_W-1:0] NXT =
               prefix_match_len(PATTERN, PATTERN_LEN, SRC, 1'(gb));
            assign tbl[gs*2 + gb] = NXT;
         end else begin : g_dead
            assign tbl[gs*2 + gb] = '0;
         end
      end
   end

   assign nxt_c = tbl[{s_i, b_i}];

endmodule

// File: rtl/seq_pattern_detector.sv
// Parametrised serial bit-pattern detector (prefix-length / KMP state machine).
// Optional match counter enabled by macro SEQ_DET_COUNT_EN.
//   clk, rst    : clock, asynchronous active-high reset
//   clear       : synchronous clear of state and counter (beats x_valid)
//   x_valid, x  : qualified serial input bit
//   y           : match indication (registered Moore or combinational Mealy)
//   state_dbg   : current prefix length 0..PATTERN_LEN
//   match_count : saturating match count (SEQ_DET_COUNT_EN only)
module seq_pattern_detector
   import seq_det_pkg::*;
#(
   parameter int unsigned PATTERN_LEN = 3,
   parameter logic [SEQ_DET_MAX_LEN-1:0] PATTERN = 16'b011,
   parameter int unsigned MOORE       = SEQ_DET_MOORE,
   parameter int unsigned OVERLAP     = 1,
   parameter int unsigned COUNT_W     = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               x_valid,
   input  logic               x,
   output logic               y,
   output logic [STATE_W-1:0] state_dbg
`ifdef SEQ_DET_COUNT_EN
   ,
   output logic [COUNT_W-1:0] match_count
`endif
);

   if (PATTERN_LEN < 1 || PATTERN_LEN > SEQ_DET_MAX_LEN) begin : g_bad_len
      $error("seq_pattern_detector: PATTERN_LEN must be within 1..16");
   end

   localparam logic [STATE_W-1:0] FULL = STATE_W'(PATTERN_LEN);

   logic [STATE_W-1:0] state_q, state_d;
   logic [STATE_W-1:0] nxt_c;
   logic               match_c;

   seq_det_next_state #(
      .PATTERN_LEN (PATTERN_LEN),
      .PATTERN     (PATTERN),
      .OVERLAP     (OVERLAP)
   ) u_next (
      .s_i   (state_q),
      .b_i   (x),
      .nxt_c (nxt_c)
   );

   assign match_c = x_valid & ~clear & (nxt_c == FULL);

   // Next state: clear wins, invalid bits leave the history untouched
   always_comb begin
      state_d = state_q;
      if (clear)        state_d = '0;
      else if (x_valid) state_d = nxt_c;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= '0;
      else     state_q <= state_d;
   end

   assign state_dbg = state_q;

   if (MOORE == SEQ_DET_MOORE) begin : g_moore
      logic y_q, y_d;
      // Tracks state==FULL; holds across gaps in x_valid
      always_comb begin
         y_d = y_q;
         if (clear | x_valid) y_d = match_c;
      end
      always_ff @(posedge clk or posedge rst) begin
         if (rst) y_q <= 1'b0;
         else     y_q <= y_d;
      end
      assign y = y_q;
   end else begin : g_mealy
      assign y = match_c;
   end

`ifdef SEQ_DET_COUNT_EN
   logic [COUNT_W-1:0] count_q, count_d;

   // Saturating counter of match events
   always_comb begin
      count_d = count_q;
      if (clear) count_d = '0;
      else if (match_c && (count_q != {COUNT_W{1'b1}})) count_d = count_q + COUNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign match_count = count_q;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
module tb_seq_pattern_detector;

   logic clk, rst, clear, x_valid, x;

   logic       y_moore, y_mealy, y_ov, y_nov, y_len1;
   logic [4:0] s_moore, s_mealy, s_ov, s_nov, s_len1;
`ifdef SEQ_DET_COUNT_EN
   logic [7:0] c_moore, c_mealy, c_ov, c_nov, c_len1;
   logic [1:0] c_sat;
   logic       y_sat;
   logic [4:0] s_sat;
`endif

   int n_total = 0;
   int n_pass  = 0;

   seq_pattern_detector u_moore (
      .clk(clk), .rst(rst), .clear(clear), .x_valid(x_valid), .x(x),
      .y(y_moore), .state_dbg(s_moore)
`ifdef SEQ_DET_COUNT_EN
      , .match_count(c_moore)
`endif
   );

   seq_pattern_detector #(.MOORE(0)) u_mealy (
      .clk(clk), .rst(rst), .clear(clear), .x_valid(x_valid), .x(x),
      .y(y_mealy), .state_dbg(s_mealy)
`ifdef SEQ_DET_COUNT_EN
      , .match_count(c_mealy)
`endif
   );

   seq_pattern_detector #(.PATTERN_LEN(4), .PATTERN(16'b1010), .OVERLAP(1)) u_ov (
      .clk(clk), .rst(rst), .clear(clear), .x_valid(x_valid), .x(x),
      .y(y_ov), .state_dbg(s_ov)
`ifdef SEQ_DET_COUNT_EN
      , .match_count(c_ov)
`endif
   );

   seq_pattern_detector #(.PATTERN_LEN(4), .PATTERN(16'b1010), .OVERLAP(0)) u_nov (
      .clk(clk), .rst(rst), .clear(clear), .x_valid(x_valid), .x(x),
      .y(y_nov), .state_dbg(s_nov)
`ifdef SEQ_DET_COUNT_EN
      , .match_count(c_nov)
`endif
   );

   seq_pattern_detector #(.PATTERN_LEN(1), .PATTERN(16'b1)) u_len1 (
      .clk(clk), .rst(rst), .clear(clear), .x_valid(x_valid), .x(x),
      .y(y_len1), .state_dbg(s_len1)
`ifdef SEQ_DET_COUNT_EN
      , .match_count(c_len1)
`endif
   );

`ifdef SEQ_DET_COUNT_EN
   seq_pattern_detector #(.COUNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .clear(clear), .x_valid(x_valid), .x(x),
      .y(y_sat), .state_dbg(s_sat), .match_count(c_sat)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       clr;
      logic       v;
      logic       b;
      logic       e_mealy;   // Mealy y while the bit is presented
      logic       e_moore;   // Moore y after the edge
      logic [4:0] e_state;   // prefix length after the edge
   } vec_t;

   vec_t tbl [19];

   typedef struct {
      logic       b;
      logic [4:0] e_s_ov;
      logic       e_y_ov;
      logic [4:0] e_s_nov;
      logic       e_y_nov;
      logic       e_y_len1;
   } pvec_t;

   pvec_t ptbl [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic step(input logic c, input logic v, input logic b);
      clear = c; x_valid = v; x = b;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; x_valid = 1'b0; x = 1'b0;

      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1};
      tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd2};
      tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1};
      tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd2};
      tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3};
      tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1};
      tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd2};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2};
      tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3};
      tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3};
      tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3};
      tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
      tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1};
      tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd2};
      tbl[18] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0};

      ptbl[0] = '{1'b1, 5'd1, 1'b0, 5'd1, 1'b0, 1'b1};
      ptbl[1] = '{1'b0, 5'd2, 1'b0, 5'd2, 1'b0, 1'b0};
      ptbl[2] = '{1'b1, 5'd3, 1'b0, 5'd3, 1'b0, 1'b1};
      ptbl[3] = '{1'b0, 5'd4, 1'b1, 5'd4, 1'b1, 1'b0};
      ptbl[4] = '{1'b1, 5'd3, 1'b0, 5'd1, 1'b0, 1'b1};
      ptbl[5] = '{1'b0, 5'd4, 1'b1, 5'd2, 1'b0, 1'b0};

      // Reset state
      #12;
      check("reset moore_y", 32'(y_moore), 32'd0);
      check("reset state", 32'(s_moore), 32'd0);
      check("reset mealy_y", 32'(y_mealy), 32'd0);
`ifdef SEQ_DET_COUNT_EN
      check("reset count", 32'(c_moore), 32'd0);
`endif
      #4;
      rst = 1'b0;

      // Default pattern 011: Moore vs Mealy, gaps, clear priority
      for (int i = 0; i < 19; i++) begin
         clear = tbl[i].clr; x_valid = tbl[i].v; x = tbl[i].b;
         #3;
         check($sformatf("row%0d mealy_y", i), 32'(y_mealy), 32'(tbl[i].e_mealy));
         @(posedge clk);
         #1;
         check($sformatf("row%0d moore_y", i), 32'(y_moore), 32'(tbl[i].e_moore));
         check($sformatf("row%0d moore_state", i), 32'(s_moore), 32'(tbl[i].e_state));
         check($sformatf("row%0d mealy_state", i), 32'(s_mealy), 32'(tbl[i].e_state));
      end
`ifdef SEQ_DET_COUNT_EN
      check("clear count", 32'(c_moore), 32'd0);
      check("clear count mealy", 32'(c_mealy), 32'd0);
`endif

      // Pattern 1010, overlapping vs non-overlapping; PATTERN_LEN=1 alongside
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b1, ptbl[i].b);
         check($sformatf("p%0d ov_state", i), 32'(s_ov), 32'(ptbl[i].e_s_ov));
         check($sformatf("p%0d ov_y", i), 32'(y_ov), 32'(ptbl[i].e_y_ov));
         check($sformatf("p%0d nov_state", i), 32'(s_nov), 32'(ptbl[i].e_s_nov));
         check($sformatf("p%0d nov_y", i), 32'(y_nov), 32'(ptbl[i].e_y_nov));
         check($sformatf("p%0d len1_y", i), 32'(y_len1), 32'(ptbl[i].e_y_len1));
         check($sformatf("p%0d len1_state", i), 32'(s_len1), 32'(ptbl[i].e_y_len1));
      end
`ifdef SEQ_DET_COUNT_EN
      check("ov count", 32'(c_ov), 32'd2);
      check("nov count", 32'(c_nov), 32'd1);
      check("len1 count", 32'(c_len1), 32'd3);
`endif

      // Async reset mid-cycle after a match
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      x_valid = 1'b0;
      check("pre_rst moore_y", 32'(y_moore), 32'd1);
      check("pre_rst state", 32'(s_moore), 32'd3);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst moore_y", 32'(y_moore), 32'd0);
      check("async_rst state", 32'(s_moore), 32'd0);
      check("async_rst ov_state", 32'(s_ov), 32'd0);
`ifdef SEQ_DET_COUNT_EN
      check("async_rst count", 32'(c_moore), 32'd0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;

`ifdef SEQ_DET_COUNT_EN
      // Saturation of a 2-bit counter over five matches
      step(1'b1, 1'b0, 1'b0);
      for (int n = 1; n <= 5; n++) begin
         step(1'b0, 1'b1, 1'b0);
         step(1'b0, 1'b1, 1'b1);
         step(1'b0, 1'b1, 1'b1);
         check($sformatf("sat n%0d", n), 32'(c_sat), (n > 3) ? 32'd3 : 32'(n));
         check($sformatf("cnt8 n%0d", n), 32'(c_moore), 32'(n));
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/seq_pattern_detector.md
Name: seq_pattern_detector

Overview:
- Parametrised serial bit-pattern detector for any pattern up to 16 bits, with selectable Moore or Mealy output and an overlapping or non-overlapping match policy.
- Next generation of the fixed 3-bit "011" detectors. Sits on a 1-bit serial data path, for example a framing/sync-word hunt after a deserialiser.
- Uses a prefix-length (KMP-style) state machine, with the transition table computed at elaboration from the PATTERN parameter.

Parameters:
PATTERN_LEN, 3, pattern length in bits, legal range 1..16
PATTERN, 16'b011, pattern bits in PATTERN[PATTERN_LEN-1:0]; bit PATTERN_LEN-1 is the first bit received
MOORE, 1, 1 = registered Moore output; 0 = combinational Mealy output
OVERLAP, 1, 1 = overlapping matches allowed; 0 = restart from empty history after each match
COUNT_W, 8, width of the match counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
clear  in  1  synchronous clear of state and counter
x_valid  in  1  qualifies x; x is ignored when low
x  in  1  serial data bit
y  out  1  match indication
state_dbg  out  5  current prefix-length state, 0..PATTERN_LEN
match_count  out  COUNT_W  saturating match count (present only with SEQ_DET_COUNT_EN)

Behaviour:
- State register s holds the length of the longest pattern prefix that is a suffix of the accepted bits. Range is 0..PATTERN_LEN, so PATTERN_LEN+1 states in both modes.
- Reset (async): s=0, y=0, match_count=0.
- Transition function d(s,b) is the longest k<=PATTERN_LEN such that prefix_k equals the suffix of (prefix_s followed by b).
  - Non-overlap mode: from s=PATTERN_LEN, use d(0,b) instead.
  - d is computed by a constant function at elaboration; no runtime pattern search.
- Clock edge with x_valid=1 and clear=0: s <= d(s,x).
- Clock edge with x_valid=0: s holds.
- clear=1 takes priority over x_valid. s <= 0, count <= 0, and the bit on x is discarded.
- Match event: x_valid & ~clear & (d(s,x)==PATTERN_LEN).
- Moore output: y = (s==PATTERN_LEN).
  - Asserted one cycle after the edge that accepts the last pattern bit.
  - Held while x_valid stays low.
- Mealy output: y = match event, combinational, same cycle as the last bit. y=0 whenever x_valid=0.
- Output latency, Moore vs Mealy: Moore y rises exactly one clock later than Mealy y for the same stream.
- PATTERN_LEN=1: the detector degenerates to s in {0,1}. Moore y then equals the registered "last bit==PATTERN[0]".
- Reset asserted mid-pattern: partial prefix is lost and detection restarts at s=0.
- Illegal parameters (PATTERN_LEN outside 1..16): elaboration error via generate-time check.

Optional Feature:
- Macro: SEQ_DET_COUNT_EN.
- Defined:
  - match_count port exists.
  - Increments by 1 on every match event, in both modes, at the edge accepting the last bit.
  - Saturates at 2^COUNT_W-1; no wrap.
  - Cleared by rst or clear.
- Undefined: port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Package seq_det_pkg:
  - SEQ_DET_MAX_LEN=16
  - STATE_W=5
  - mode constants SEQ_DET_MOORE=1, SEQ_DET_MEALY=0
  - the constant function computing prefix-match length
- Sub-module seq_det_next_state: purely combinational d(s,b) lookup built from the parameters. The top level holds the state register, clear/valid logic, output and counter.

Test Plan:
- Default params (011, Moore, overlap), x=0,1,1,0,1,1 every cycle -> y=1 in the cycle after the 3rd bit and after the 6th bit; state_dbg sequence 1,2,3,1,2,3.
- Same stream with MOORE=0 -> y=1 combinationally during the 3rd and 6th bits, one cycle earlier than Moore; y=0 when x_valid=0.
- PATTERN=4'b1010, PATTERN_LEN=4, stream 1,0,1,0,1,0 -> OVERLAP=1 gives matches at bits 4 and 6 (count=2); OVERLAP=0 gives a match at bit 4 only (count=1).
- Default params, x_valid toggling 1,0,1,0,1 with x=0,-,1,-,1 -> a match still occurs; state holds through the gaps; Moore y holds high while x_valid=0 after the match.
- Default params, stream 0,1 then clear=1 with x=1 -> no match, s=0, count=0. Stream 0,1 then async rst mid-cycle -> y=0 and s=0 immediately.
- SEQ_DET_COUNT_EN with COUNT_W=2, 5 matches -> match_count saturates at 3.
